// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_responder data-memory block: sweep state,
// trace record layout, store legality and byte-lane merge.
package dm_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } dm_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trace_rec_t;

   // A zero pattern is not a store and is never "legal"; callers test for it separately.
   function automatic logic byteen_legal(input logic [3:0] byteen, input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (byteen)
         4'b1111, 4'b0011: ok = (addr_lo == 2'd0);
         4'b1100:          ok = (addr_lo == 2'd2);
         4'b0001:          ok = (addr_lo == 2'd0);
         4'b0010:          ok = (addr_lo == 2'd1);
         4'b0100:          ok = (addr_lo == 2'd2);
         4'b1000:          ok = (addr_lo == 2'd3);
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = byteen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Core data port plus trace sink handshake of dm_responder; master = core/sink side,
// slave = responder side.
interface dm_responder_if;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_inst_addr;
   logic [31:0] m_data_rdata;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;

   modport master (
      output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
      input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data
   );

   modport slave (
      input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
      output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data
   );
endinterface

// File: rtl/dm_trace_fifo.sv
// Store-trace FIFO for dm_responder: synchronous push/pop, extra-bit pointers for
// full/empty, a push into a full FIFO is accepted only when a pop happens at the same edge.
module dm_trace_fifo
   import dm_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  trace_rec_t push_rec,
   input  logic       pop,
   output trace_rec_t head_rec,
   output logic       full,
   output logic       empty,
   output logic       drop
);
   localparam int PTR_W = $clog2(DEPTH);

   trace_rec_t        store [DEPTH];
   logic [PTR_W:0]    wr_q, wr_d;
   logic [PTR_W:0]    rd_q, rd_d;
   logic              do_push;
   logic              do_pop;

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign drop     = push && !do_push;
   assign head_rec = store[rd_q[PTR_W-1:0]];

   always_comb begin
      wr_d = wr_q + (PTR_W+1)'(do_push);
      rd_d = rd_q + (PTR_W+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wr_q[PTR_W-1:0]] <= push_rec;
      end
   end
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zeroing sweep after reset, combinational reads, checked
// byte-enabled stores. Define DM_TRACE_EN to build the store-trace FIFO.
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   dm_responder_if.slave        bus,
   output logic                 ready,
   output logic                 err_align,
   output logic                 err_range,
   output logic                 trace_overflow
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   dm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              err_align_q, err_align_d;
   logic              err_range_q, err_range_d;

   logic [ADDR_W-1:0] word_idx;
   logic              in_range;
   logic              store_req;
   logic              legal;
   logic              commit;
   logic [31:0]       old_word;
   logic [31:0]       merged_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   assign word_idx    = bus.m_data_addr[ADDR_W+1:2];
   assign in_range    = (bus.m_data_addr[31:ADDR_W+2] == '0);
   assign store_req   = (bus.m_data_byteen != 4'b0000);
   assign legal       = byteen_legal(bus.m_data_byteen, bus.m_data_addr[1:0]);
   assign commit      = (state_q == RUN) && store_req && legal && in_range;
   assign old_word    = mem[word_idx];
   assign merged_word = lane_merge(old_word, bus.m_data_wdata, bus.m_data_byteen);

   assign bus.m_data_rdata = ((state_q == RUN) && in_range) ? old_word : 32'h0;
   assign ready            = ready_q;
   assign err_align        = err_align_q;
   assign err_range        = err_range_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      err_align_d = err_align_q;
      err_range_d = err_range_q;
      mem_we      = 1'b0;
      mem_waddr   = word_idx;
      mem_wdata   = merged_word;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = 32'h0;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
               state_d = RUN;
               ready_d = 1'b1;
            end
         end
         RUN: begin
            mem_we = commit;
            // Both flags may set on the same store.
            if (store_req && !legal) err_align_d = 1'b1;
            if (store_req && !in_range) err_range_d = 1'b1;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         err_align_q <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         err_align_q <= err_align_d;
         err_range_q <= err_range_d;
      end
   end

   // The array has no reset; gating with reset_n keeps the held-reset sweep state from writing.
   always_ff @(posedge clk) begin
      if (mem_we && reset_n) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

`ifdef DM_TRACE_EN
   trace_rec_t push_rec;
   trace_rec_t head_rec;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;
   logic       push_drop;
   logic       overflow_q, overflow_d;

   assign push_rec = '{pc: bus.m_inst_addr, addr: bus.m_data_addr, data: merged_word};
   assign fifo_pop = !fifo_empty && bus.trace_ready;

   dm_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (commit),
      .push_rec (push_rec),
      .pop      (fifo_pop),
      .head_rec (head_rec),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .drop     (push_drop)
   );

   // Record fields read 0 when nothing is queued, so unwritten slots never leak out.
   assign bus.trace_valid = !fifo_empty;
   assign bus.trace_pc    = fifo_empty ? 32'h0 : head_rec.pc;
   assign bus.trace_addr  = fifo_empty ? 32'h0 : head_rec.addr;
   assign bus.trace_data  = fifo_empty ? 32'h0 : head_rec.data;
   assign trace_overflow  = overflow_q;

   always_comb begin
      overflow_d = overflow_q | push_drop;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   logic unused_full;
   assign unused_full = fifo_full;
`else
   logic [32:0] unused_trace;
   localparam int unused_depth = TRACE_DEPTH;
   assign unused_trace    = {bus.trace_ready, bus.m_inst_addr};
   assign bus.trace_valid = 1'b0;
   assign bus.trace_pc    = 32'h0;
   assign bus.trace_addr  = 32'h0;
   assign bus.trace_data  = 32'h0;
   assign trace_overflow  = 1'b0;
`endif

endmodule
